// File: rtl/bank_state_if.sv
// bank_state_if: command strobes from the scheduler and per-bank status back to it.
interface bank_state_if #(
    parameter int BANK_ADDR_BITS = 2,
    parameter int ROW_ADDR_BITS  = 13
);
    logic [BANK_ADDR_BITS-1:0] sdram_bank_addr;
    logic [ROW_ADDR_BITS-1:0]  sdram_row_addr;
    logic                      precharge_all;
    logic                      precharge_row;
    logic                      activate_row;
    logic                      access;
    logic                      row_active;
    logic                      row_addr_match;
    logic                      tras_done;
    logic                      tras_all_done;
    logic                      trc_done;
    logic                      trcd_done;
    logic                      trp_done;
    logic                      trp_all_done;
    logic                      idle_close_req;
    logic [BANK_ADDR_BITS-1:0] idle_close_bank;
    logic                      cmd_error;

    modport master (
        output sdram_bank_addr, sdram_row_addr, precharge_all, precharge_row, activate_row, access,
        input  row_active, row_addr_match, tras_done, tras_all_done, trc_done, trcd_done,
               trp_done, trp_all_done, idle_close_req, idle_close_bank, cmd_error
    );
    modport slave (
        input  sdram_bank_addr, sdram_row_addr, precharge_all, precharge_row, activate_row, access,
        output row_active, row_addr_match, tras_done, tras_all_done, trc_done, trcd_done,
               trp_done, trp_all_done, idle_close_req, idle_close_bank, cmd_error
    );
endinterface

// File: rtl/bank_state_ctrl.sv
// bank_state_ctrl: per-bank open/row tracking, SDRAM timing timers, idle-row close request and command checking.
module bank_state_ctrl #(
    parameter int BANK_ADDR_BITS     = 2,
    parameter int ROW_ADDR_BITS      = 13,
    parameter int SDRAM_T_RC_PS      = 66000,
    parameter int SDRAM_T_RAS_MIN_PS = 42000,
    parameter int SDRAM_T_RCD_PS     = 20000,
    parameter int SDRAM_T_RP_PS      = 20000,
    parameter int SYSCLK_PERIOD_PS   = 10000,
    parameter int ROW_IDLE_LIMIT     = 64
) (
    input logic        clk,
    input logic        rst,
    bank_state_if.slave bus
);
    localparam int NB    = 2 ** BANK_ADDR_BITS;
    localparam int N_RAS = (SDRAM_T_RAS_MIN_PS + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int N_RC  = (SDRAM_T_RC_PS + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int N_RCD = (SDRAM_T_RCD_PS + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int N_RP  = (SDRAM_T_RP_PS + SYSCLK_PERIOD_PS - 1) / SYSCLK_PERIOD_PS;
    localparam int W_RAS = N_RAS > 1 ? $clog2(N_RAS) : 1;
    localparam int W_RC  = N_RC > 1 ? $clog2(N_RC) : 1;
    localparam int W_RCD = N_RCD > 1 ? $clog2(N_RCD) : 1;
    localparam int W_RP  = N_RP > 1 ? $clog2(N_RP) : 1;
    localparam int IW    = ROW_IDLE_LIMIT > 0 ? $clog2(ROW_IDLE_LIMIT + 1) : 1;
    localparam logic [W_RAS-1:0] L_RAS = W_RAS'(N_RAS > 1 ? N_RAS - 1 : 0);
    localparam logic [W_RC-1:0]  L_RC  = W_RC'(N_RC > 1 ? N_RC - 1 : 0);
    localparam logic [W_RCD-1:0] L_RCD = W_RCD'(N_RCD > 1 ? N_RCD - 1 : 0);
    localparam logic [W_RP-1:0]  L_RP  = W_RP'(N_RP > 1 ? N_RP - 1 : 0);
    localparam logic [IW-1:0]    IDLE_MAX = IW'(ROW_IDLE_LIMIT);

    logic [NB-1:0]             open_q, open_d, pre, act, flag;
    logic [ROW_ADDR_BITS-1:0]  row_q [NB], row_d [NB];
    logic [W_RAS-1:0]          tras_q [NB], tras_d [NB];
    logic [W_RC-1:0]           trc_q [NB], trc_d [NB];
    logic [W_RCD-1:0]          trcd_q [NB], trcd_d [NB];
    logic [W_RP-1:0]           trp_q [NB], trp_d [NB];
    logic [IW-1:0]             idle_q [NB], idle_d [NB];
    logic                      req_q, req_d, err_q, err_d;
    logic [BANK_ADDR_BITS-1:0] bank_q, bank_d, s;
    logic                      tras_done, trc_done, trcd_done, trp_done, tras_all, trp_all;

    assign s         = bus.sdram_bank_addr;
    assign tras_done = tras_q[s] == '0;
    assign trc_done  = trc_q[s] == '0;
    assign trcd_done = trcd_q[s] == '0;
    assign trp_done  = trp_q[s] == '0;

    assign bus.row_active      = open_q[s];
    assign bus.row_addr_match  = open_q[s] && row_q[s] == bus.sdram_row_addr;
    assign bus.tras_done       = tras_done;
    assign bus.trc_done        = trc_done;
    assign bus.trcd_done       = trcd_done;
    assign bus.trp_done        = trp_done;
    assign bus.tras_all_done   = tras_all;
    assign bus.trp_all_done    = trp_all;
    assign bus.idle_close_req  = req_q;
    assign bus.idle_close_bank = bank_q;
    assign bus.cmd_error       = err_q;

    // Flags come from next state so the request drops the cycle after the bank is closed or touched.
    // Walking down from the top bank leaves the lowest flagged index in bank_d.
    always_comb begin
        pre      = '0;
        act      = '0;
        flag     = '0;
        open_d   = open_q;
        row_d    = row_q;
        tras_d   = tras_q;
        trc_d    = trc_q;
        trcd_d   = trcd_q;
        trp_d    = trp_q;
        idle_d   = idle_q;
        tras_all = 1'b1;
        trp_all  = 1'b1;
        req_d    = 1'b0;
        bank_d   = bank_q;
        for (int b = NB - 1; b >= 0; b--) begin
            pre[b]    = bus.precharge_all || (bus.precharge_row && s == BANK_ADDR_BITS'(b));
            act[b]    = bus.activate_row && s == BANK_ADDR_BITS'(b) && !pre[b];
            open_d[b] = !pre[b] && (act[b] || open_q[b]);
            row_d[b]  = act[b] ? bus.sdram_row_addr : row_q[b];
            tras_d[b] = act[b] ? L_RAS : tras_q[b] - W_RAS'(tras_q[b] != '0);
            trc_d[b]  = act[b] ? L_RC : trc_q[b] - W_RC'(trc_q[b] != '0);
            trcd_d[b] = act[b] ? L_RCD : trcd_q[b] - W_RCD'(trcd_q[b] != '0);
            trp_d[b]  = pre[b] ? L_RP : trp_q[b] - W_RP'(trp_q[b] != '0);
            idle_d[b] = (!open_d[b] || act[b] || (bus.access && s == BANK_ADDR_BITS'(b))) ? '0
                        : idle_q[b] + IW'(idle_q[b] != IDLE_MAX);
            flag[b]   = ROW_IDLE_LIMIT != 0 && open_d[b] && idle_d[b] == IDLE_MAX;
            req_d     = req_d || flag[b];
            bank_d    = flag[b] ? BANK_ADDR_BITS'(b) : bank_d;
            tras_all  = tras_all && tras_q[b] == '0;
            trp_all   = trp_all && trp_q[b] == '0;
        end
        err_d = (bus.activate_row && (open_q[s] || !trc_done || !trp_done))
             || (bus.precharge_row && !tras_done)
             || (bus.precharge_all && !tras_all)
             || (bus.access && (!open_q[s] || !trcd_done));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
            req_q  <= 1'b0;
            err_q  <= 1'b0;
            bank_q <= '0;
            for (int b = 0; b < NB; b++) begin
                row_q[b]  <= '0;
                tras_q[b] <= '0;
                trc_q[b]  <= '0;
                trcd_q[b] <= '0;
                trp_q[b]  <= '0;
                idle_q[b] <= '0;
            end
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            tras_q <= tras_d;
            trc_q  <= trc_d;
            trcd_q <= trcd_d;
            trp_q  <= trp_d;
            idle_q <= idle_d;
            req_q  <= req_d;
            bank_q <= bank_d;
            err_q  <= err_d;
        end
    end
endmodule
